// File: rtl/baud_ctrl.sv
// Run-time baud-rate controller: 16x oversampling tick plus bit strobe,
// with divisor updates deferred until both UART directions are idle.
module baud_ctrl #(
  parameter int DVSR_W   = 11,
  parameter int DVSR_RST = 650
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wr_dvsr,
  input  logic [DVSR_W-1:0] dvsr_in,
  input  logic              tx_busy,
  input  logic              rx_busy,
  output logic              tick,
  output logic              bit_tick,
  output logic [DVSR_W-1:0] dvsr_q,
  output logic              pend
);

  typedef enum logic [0:0] {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [DVSR_W-1:0] cnt_r, cnt_s;
  logic [3:0]        sub_r, sub_s;
  logic [DVSR_W-1:0] act_r, act_s;
  logic [DVSR_W-1:0] nxt_r, nxt_s;
  logic              pend_r, pend_s;
  logic              tick_s;
  logic              apply_s;

  // Output decode, purely from registered state.
  always_comb begin
    tick_s   = (state_r == RUN) && (cnt_r == act_r);
    tick     = tick_s;
    bit_tick = tick_s && (sub_r == 4'd15);
    dvsr_q   = act_r;
    pend     = pend_r;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= STOP;
      cnt_r   <= '0;
      sub_r   <= 4'd0;
      act_r   <= DVSR_W'(DVSR_RST);
      nxt_r   <= '0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sub_r   <= sub_s;
      act_r   <= act_s;
      nxt_r   <= nxt_s;
      pend_r  <= pend_s;
    end
  end

  // Next-state logic: counters, FSM and divisor handoff.
  always_comb begin
    state_s = state_r;
    cnt_s   = '0;
    sub_s   = 4'd0;
    apply_s = 1'b0;

    case (state_r)
      STOP: begin
        // Busy inputs do not matter here: nothing is being clocked out.
        apply_s = pend_r;
        if (en) begin
          state_s = RUN;
        end else begin
          state_s = STOP;
        end
      end
      RUN: begin
        apply_s = pend_r && tick_s && !tx_busy && !rx_busy;
        if (!en) begin
          state_s = STOP;
        end else if (tick_s) begin
          state_s = RUN;
          cnt_s   = '0;
          sub_s   = apply_s ? 4'd0 : sub_r + 4'd1;
        end else begin
          state_s = RUN;
          cnt_s   = cnt_r + DVSR_W'(1);
          sub_s   = sub_r;
        end
      end
      default: begin
        state_s = STOP;
      end
    endcase

    if (apply_s) begin
      act_s = nxt_r;
    end else begin
      act_s = act_r;
    end

    // A write always re-arms pend, even when it lands on an apply edge.
    if (wr_dvsr) begin
      nxt_s  = dvsr_in;
      pend_s = 1'b1;
    end else begin
      nxt_s  = nxt_r;
      pend_s = apply_s ? 1'b0 : pend_r;
    end
  end

endmodule
